// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default frame width and parity-type codes.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register plus bit counter for the UART transmitter data phase.
// ser_bit is the data bit to be on the line in the cycle after the current edge.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  tx_clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    always_comb begin
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        if (load) begin
            shift_next = load_data;
            cnt_next   = '0;
        end else if (shift) begin
            shift_next = shift_reg >> 1;
            // Saturate so the counter never wraps past the last data bit.
            if (cnt_reg != LAST_IDX) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign ser_bit  = shift_next[0];
    assign ser_done = (cnt_reg == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even/odd parity, one stop bit.
// Outputs are registered from the next state so the start bit appears the cycle after acceptance.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  tx_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic                  tx_out,
    output logic                  busy
);

    uart_state_t state_reg, state_next;
    logic        tx_out_reg, tx_next;
    logic        busy_reg, busy_next;
    logic        pen_reg, par_reg;
    logic        accept, shift, ser_bit, ser_done;

    // STOP accepts as well as IDLE, giving zero-gap back-to-back frames.
    assign accept = data_valid && (state_reg == ST_IDLE || state_reg == ST_STOP);
    assign shift  = (state_reg == ST_DATA) && (state_next == ST_DATA);

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_serializer (
        .tx_clk   (tx_clk),
        .rst      (rst),
        .load     (accept),
        .load_data(p_data),
        .shift    (shift),
        .ser_bit  (ser_bit),
        .ser_done (ser_done)
    );

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            tx_out_reg <= 1'b1;
            busy_reg   <= 1'b0;
            pen_reg    <= 1'b0;
            par_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            tx_out_reg <= tx_next;
            busy_reg   <= busy_next;
            if (accept) begin
                pen_reg <= parity_enable;
                par_reg <= (^p_data) ^ (parity_type == PARITY_ODD);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (data_valid) state_next = ST_START;
            ST_START:  state_next = ST_DATA;
            ST_DATA:   if (ser_done) state_next = pen_reg ? ST_PARITY : ST_STOP;
            ST_PARITY: state_next = ST_STOP;
            ST_STOP:   state_next = data_valid ? ST_START : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        unique case (state_next)
            ST_START:  begin tx_next = 1'b0;    busy_next = 1'b1; end
            ST_DATA:   begin tx_next = ser_bit; busy_next = 1'b1; end
            ST_PARITY: begin tx_next = par_reg; busy_next = 1'b1; end
            default:   begin tx_next = 1'b1;    busy_next = 1'b0; end
        endcase
    end

    assign tx_out = tx_out_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model queues expected line waveforms,
// and a per-cycle monitor compares tx_out/busy against them.
module tb_uart_tx;

    logic       tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       parity_enable = 1'b0;
    logic       parity_type = 1'b0;
    logic       tx_out;
    logic       busy;

    typedef struct {
        int          start_edge;
        int          n;
        logic [15:0] bits;
        logic [7:0]  data;
    } frame_t;

    frame_t exp_q[$];
    int     rst_q[$];
    int     edge_cnt = 0;
    int     busy_until = 0;
    int     total = 0;
    int     bad = 0;
    bit     in_frame = 0;

    uart_tx #(.DATA_WIDTH(8)) dut (
        .tx_clk       (tx_clk),
        .rst          (rst),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .tx_out       (tx_out),
        .busy         (busy)
    );

    always #5 tx_clk = ~tx_clk;
    always @(posedge tx_clk) edge_cnt <= edge_cnt + 1;

    function automatic frame_t make_frame(int e, logic [7:0] d, logic pen, logic pt);
        frame_t f;
        f.start_edge = e;
        f.data = d;
        f.bits = '0;
        f.n = 0;
        f.bits[f.n] = 1'b0; f.n++;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.n] = d[i]; f.n++;
        end
        if (pen) begin
            f.bits[f.n] = (($countones(d) % 2) == 1) ^ pt; f.n++;
        end
        f.bits[f.n] = 1'b1; f.n++;
        return f;
    endfunction

    // Drive one cycle of inputs; the model decides acceptance for the upcoming edge.
    task automatic drive(input logic dv, input logic [7:0] d, input logic pen,
                         input logic pt, input logic r);
        int e;
        @(negedge tx_clk);
        data_valid = dv; p_data = d; parity_enable = pen; parity_type = pt; rst = r;
        e = edge_cnt + 1;
        if (r) begin
            rst_q.push_back(e);
            busy_until = 0;
        end else if (dv && e >= busy_until) begin
            frame_t f;
            f = make_frame(e, d, pen, pt);
            exp_q.push_back(f);
            busy_until = e + f.n;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: one check per cycle, frames popped when their start bit is due.
    initial begin
        frame_t cur;
        int     idx;
        int     e;
        logic   exp_tx, exp_busy;
        idx = 0;
        forever begin
            @(negedge tx_clk);
            e = edge_cnt;
            while (rst_q.size() > 0 && rst_q[0] < e) void'(rst_q.pop_front());
            if (rst_q.size() > 0 && rst_q[0] == e) begin
                void'(rst_q.pop_front());
                if (in_frame) $display("frame edge=%0d data=0x%02h aborted by reset", cur.start_edge, cur.data);
                in_frame = 0;
            end else if (!in_frame && exp_q.size() > 0 && exp_q[0].start_edge == e) begin
                cur = exp_q.pop_front();
                in_frame = 1;
                idx = 0;
            end
            if (in_frame) begin
                exp_tx = cur.bits[idx];
                exp_busy = (idx < cur.n - 1);
            end else begin
                exp_tx = 1'b1;
                exp_busy = 1'b0;
            end
            total++;
            if (tx_out !== exp_tx || busy !== exp_busy) begin
                bad++;
                $display("FAIL line edge=%0d idx=%0d got tx=%b busy=%b expected tx=%b busy=%b",
                         e, in_frame ? idx : -1, tx_out, busy, exp_tx, exp_busy);
            end
            if (in_frame) begin
                idx++;
                if (idx == cur.n) begin
                    in_frame = 0;
                    $display("frame edge=%0d data=0x%02h bits=%0d done", cur.start_edge, cur.data, cur.n);
                end
            end
        end
    end

    initial begin
        int waited;
        idle(0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
        idle(3);

        drive(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        idle(13);
        drive(1'b1, 8'h05, 1'b1, 1'b1, 1'b0);
        idle(13);
        drive(1'b1, 8'h19, 1'b0, 1'b0, 1'b0);
        idle(12);

        drive(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
        idle(12);

        drive(1'b1, 8'hC8, 1'b0, 1'b0, 1'b0);
        idle(5);
        drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b1);
        idle(1);
        drive(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        idle(12);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 59) == 0);
        end
        idle(14);

        waited = 0;
        while ((exp_q.size() > 0 || in_frame) && waited < 60) begin
            @(negedge tx_clk);
            waited++;
        end
        total++;
        if (exp_q.size() > 0 || in_frame) begin
            bad++;
            $display("FAIL drain pending=%0d in_frame=%0d required pending=0 in_frame=0",
                     exp_q.size(), in_frame);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
